// File: rtl/spmv_pkg.sv
// Shared types and defaults for the SpMV calc kernel row feeder.
package spmv_pkg;

  localparam int PTR_W_DEF  = 32;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    BASE  = 2'd0,
    PTR   = 2'd1,
    TIMES = 2'd2,
    PAIRS = 2'd3
  } feed_state_t;

endpackage

// File: rtl/spmv_row_feeder_pair_join_reg.sv
// One-entry (A, B) operand register. Both halves load together; each half
// drains on its own handshake so the multiplier can take them separately.
module pair_join_reg #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic              a_ready,
  input  logic              b_ready,
  output logic              a_pend,
  output logic              b_pend,
  output logic [DATA_W-1:0] a_q,
  output logic [DATA_W-1:0] b_q,
  output logic              free
);

  // Entry can take a new pair only if every set flag is leaving this cycle.
  always_comb begin
    free = (!a_pend || a_ready) && (!b_pend || b_ready);
  end

  // Load sets both flags; otherwise each flag clears on its own handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_pend <= 1'b0;
      b_pend <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (load) begin
      a_pend <= 1'b1;
      b_pend <= 1'b1;
      a_q    <= a_data;
      b_q    <= b_data;
    end else begin
      if (a_pend && a_ready) a_pend <= 1'b0;
      if (b_pend && b_ready) b_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/spmv_row_feeder.sv
// CSR row feeder: turns row pointers into a TIMES count followed by exactly
// that many (value, x[col]) operand pairs for the dot-product unit.
module spmv_row_feeder
  import spmv_pkg::*;
#(
  parameter int PTR_W  = PTR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PTR_W-1:0]  S_AXIS_ROWPTR_tdata,
  input  logic              S_AXIS_ROWPTR_tvalid,
  output logic              S_AXIS_ROWPTR_tready,
  input  logic              S_AXIS_ROWPTR_tlast,
  input  logic [DATA_W-1:0] S_AXIS_VAL_tdata,
  input  logic              S_AXIS_VAL_tvalid,
  output logic              S_AXIS_VAL_tready,
  input  logic [DATA_W-1:0] S_AXIS_VEC_tdata,
  input  logic              S_AXIS_VEC_tvalid,
  output logic              S_AXIS_VEC_tready,
  output logic [PTR_W-1:0]  M_AXIS_TIMES_tdata,
  output logic              M_AXIS_TIMES_tvalid,
  input  logic              M_AXIS_TIMES_tready,
  output logic [DATA_W-1:0] M_AXIS_A_tdata,
  output logic              M_AXIS_A_tvalid,
  input  logic              M_AXIS_A_tready,
  output logic [DATA_W-1:0] M_AXIS_B_tdata,
  output logic              M_AXIS_B_tvalid,
  input  logic              M_AXIS_B_tready,
  output logic [31:0]       rows_done,
  output logic              busy,
  output logic              err
);

  feed_state_t      state_q, state_d;
  logic [PTR_W-1:0] prev_q, len_q, remain_q;
  logic             last_q;
  logic [31:0]      rows_q;
  logic             err_q;

  logic ptr_hs, times_hs, pair_free, in_open, load, row_end;

  assign ptr_hs   = S_AXIS_ROWPTR_tvalid && S_AXIS_ROWPTR_tready;
  assign times_hs = M_AXIS_TIMES_tvalid && M_AXIS_TIMES_tready;
  assign load     = S_AXIS_VAL_tready && S_AXIS_VAL_tvalid && S_AXIS_VEC_tvalid;
  // Row is finished once every pair is loaded and the entry is emptying.
  assign row_end  = (state_q == PAIRS) && (remain_q == '0) && pair_free;

  pair_join_reg #(.DATA_W(DATA_W)) u_join (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .a_data  (S_AXIS_VAL_tdata),
    .b_data  (S_AXIS_VEC_tdata),
    .a_ready (M_AXIS_A_tready),
    .b_ready (M_AXIS_B_tready),
    .a_pend  (M_AXIS_A_tvalid),
    .b_pend  (M_AXIS_B_tvalid),
    .a_q     (M_AXIS_A_tdata),
    .b_q     (M_AXIS_B_tdata),
    .free    (pair_free)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= BASE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BASE:  if (ptr_hs && !S_AXIS_ROWPTR_tlast) state_d = PTR;
      PTR:   if (ptr_hs) state_d = TIMES;
      TIMES: if (times_hs) begin
               if (len_q != '0) state_d = PAIRS;
               else             state_d = last_q ? BASE : PTR;
             end
      PAIRS: if (row_end) state_d = last_q ? BASE : PTR;
      default: state_d = BASE;
    endcase
  end

  // Handshake outputs; readies are held low while reset is asserted.
  always_comb begin
    in_open              = (state_q == PAIRS) && (remain_q != '0) && pair_free;
    S_AXIS_ROWPTR_tready = !rst && ((state_q == BASE) || (state_q == PTR));
    S_AXIS_VAL_tready    = !rst && in_open;
    S_AXIS_VEC_tready    = !rst && in_open;
    M_AXIS_TIMES_tvalid  = (state_q == TIMES);
    M_AXIS_TIMES_tdata   = len_q;
    busy                 = (state_q != BASE);
    rows_done            = rows_q;
    err                  = err_q;
  end

  // Row bookkeeping: pointer difference, pairs remaining, completed rows, error.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      len_q    <= '0;
      remain_q <= '0;
      last_q   <= 1'b0;
      rows_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (ptr_hs && state_q == BASE) prev_q <= S_AXIS_ROWPTR_tdata;
      if (ptr_hs && state_q == PTR) begin
        if (S_AXIS_ROWPTR_tdata < prev_q) begin
          len_q <= '0;
          err_q <= 1'b1;
        end else begin
          len_q <= S_AXIS_ROWPTR_tdata - prev_q;
        end
        prev_q <= S_AXIS_ROWPTR_tdata;
        last_q <= S_AXIS_ROWPTR_tlast;
      end
      if (times_hs) begin
        if (len_q == '0) rows_q <= rows_q + 32'd1;
        else             remain_q <= len_q;
      end
      if (load)    remain_q <= remain_q - PTR_W'(1);
      if (row_end) rows_q <= rows_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_spmv_row_feeder.sv
// Directed bench for spmv_row_feeder: drives the three input streams from
// queues one cycle at a time and logs every output handshake.
module tb_spmv_row_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] S_AXIS_ROWPTR_tdata;
  logic        S_AXIS_ROWPTR_tvalid, S_AXIS_ROWPTR_tready, S_AXIS_ROWPTR_tlast;
  logic [63:0] S_AXIS_VAL_tdata, S_AXIS_VEC_tdata;
  logic        S_AXIS_VAL_tvalid, S_AXIS_VAL_tready, S_AXIS_VEC_tvalid, S_AXIS_VEC_tready;
  logic [31:0] M_AXIS_TIMES_tdata;
  logic        M_AXIS_TIMES_tvalid, M_AXIS_TIMES_tready;
  logic [63:0] M_AXIS_A_tdata, M_AXIS_B_tdata;
  logic        M_AXIS_A_tvalid, M_AXIS_A_tready, M_AXIS_B_tvalid, M_AXIS_B_tready;
  logic [31:0] rows_done;
  logic        busy, err;

  spmv_row_feeder dut (
    .clk(clk), .rst(rst),
    .S_AXIS_ROWPTR_tdata(S_AXIS_ROWPTR_tdata), .S_AXIS_ROWPTR_tvalid(S_AXIS_ROWPTR_tvalid),
    .S_AXIS_ROWPTR_tready(S_AXIS_ROWPTR_tready), .S_AXIS_ROWPTR_tlast(S_AXIS_ROWPTR_tlast),
    .S_AXIS_VAL_tdata(S_AXIS_VAL_tdata), .S_AXIS_VAL_tvalid(S_AXIS_VAL_tvalid),
    .S_AXIS_VAL_tready(S_AXIS_VAL_tready),
    .S_AXIS_VEC_tdata(S_AXIS_VEC_tdata), .S_AXIS_VEC_tvalid(S_AXIS_VEC_tvalid),
    .S_AXIS_VEC_tready(S_AXIS_VEC_tready),
    .M_AXIS_TIMES_tdata(M_AXIS_TIMES_tdata), .M_AXIS_TIMES_tvalid(M_AXIS_TIMES_tvalid),
    .M_AXIS_TIMES_tready(M_AXIS_TIMES_tready),
    .M_AXIS_A_tdata(M_AXIS_A_tdata), .M_AXIS_A_tvalid(M_AXIS_A_tvalid),
    .M_AXIS_A_tready(M_AXIS_A_tready),
    .M_AXIS_B_tdata(M_AXIS_B_tdata), .M_AXIS_B_tvalid(M_AXIS_B_tvalid),
    .M_AXIS_B_tready(M_AXIS_B_tready),
    .rows_done(rows_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, val_acc = 0;
  logic [32:0] ptr_q[$];
  logic [63:0] val_q[$], vec_q[$];
  logic [31:0] times_log[$];
  int          times_apos[$], times_bpos[$];
  logic [63:0] a_log[$], b_log[$];
  int          a_cyc[$], b_cyc[$];
  bit          a_rand = 1'b0, b_low = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, log handshakes just before the rising edge.
  task automatic tick();
    if (ptr_q.size() != 0) begin
      S_AXIS_ROWPTR_tvalid = 1'b1;
      S_AXIS_ROWPTR_tlast  = ptr_q[0][32];
      S_AXIS_ROWPTR_tdata  = ptr_q[0][31:0];
    end else begin
      S_AXIS_ROWPTR_tvalid = 1'b0;
      S_AXIS_ROWPTR_tlast  = 1'b0;
      S_AXIS_ROWPTR_tdata  = '0;
    end
    S_AXIS_VAL_tvalid   = (val_q.size() != 0);
    S_AXIS_VAL_tdata    = (val_q.size() != 0) ? val_q[0] : '0;
    S_AXIS_VEC_tvalid   = (vec_q.size() != 0);
    S_AXIS_VEC_tdata    = (vec_q.size() != 0) ? vec_q[0] : '0;
    M_AXIS_TIMES_tready = 1'b1;
    M_AXIS_A_tready     = a_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    M_AXIS_B_tready     = !b_low;
    #4;
    if (S_AXIS_ROWPTR_tvalid && S_AXIS_ROWPTR_tready) void'(ptr_q.pop_front());
    if (S_AXIS_VAL_tvalid && S_AXIS_VAL_tready) begin void'(val_q.pop_front()); val_acc++; end
    if (S_AXIS_VEC_tvalid && S_AXIS_VEC_tready) void'(vec_q.pop_front());
    if (M_AXIS_TIMES_tvalid && M_AXIS_TIMES_tready) begin
      times_log.push_back(M_AXIS_TIMES_tdata);
      times_apos.push_back(a_log.size());
      times_bpos.push_back(b_log.size());
    end
    if (M_AXIS_A_tvalid && M_AXIS_A_tready) begin a_log.push_back(M_AXIS_A_tdata); a_cyc.push_back(cyc); end
    if (M_AXIS_B_tvalid && M_AXIS_B_tready) begin b_log.push_back(M_AXIS_B_tdata); b_cyc.push_back(cyc); end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    times_log.delete(); times_apos.delete(); times_bpos.delete();
    a_log.delete(); b_log.delete(); a_cyc.delete(); b_cyc.delete();
    val_acc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ptr_q.delete(); val_q.delete(); vec_q.delete();
    tick(); tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic push_ptr(input logic [31:0] p, input logic last);
    ptr_q.push_back({last, p});
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(ptr_q.size() == 0 && val_q.size() == 0 && vec_q.size() == 0 &&
                 !busy && !M_AXIS_A_tvalid && !M_AXIS_B_tvalid) && n < maxc);
    chk(tag, 64'(n < maxc), 64'd1);
  endtask

  initial begin
    int bad;
    @(negedge clk);
    // Reset values while rst is held.
    tick(); tick();
    chk("rst_readies", {61'd0, S_AXIS_ROWPTR_tready, S_AXIS_VAL_tready, S_AXIS_VEC_tready}, 64'd0);
    chk("rst_valids", {61'd0, M_AXIS_TIMES_tvalid, M_AXIS_A_tvalid, M_AXIS_B_tvalid}, 64'd0);
    chk("rst_status", {31'd0, rows_done, busy, err}, 64'd0);
    chk("rst_a_data", M_AXIS_A_tdata, 64'd0);
    chk("rst_b_data", M_AXIS_B_tdata, 64'd0);
    chk("rst_times_data", 64'(M_AXIS_TIMES_tdata), 64'd0);
    rst = 1'b0;
    tick();
    chk("rowptr_ready_after_rst", 64'(S_AXIS_ROWPTR_tready), 64'd1);

    // 1: basic matrix 0,3,5.
    clear_logs();
    push_ptr(0, 0); push_ptr(3, 0); push_ptr(5, 1);
    for (int i = 1; i <= 5; i++) begin
      val_q.push_back($realtobits(real'(i)));
      vec_q.push_back($realtobits(2.0));
    end
    wait_idle("t1_idle", 100);
    chk("t1_times_n", 64'(times_log.size()), 64'd2);
    chk("t1_times0", 64'(times_log[0]), 64'd3);
    chk("t1_times1", 64'(times_log[1]), 64'd2);
    chk("t1_a_n", 64'(a_log.size()), 64'd5);
    chk("t1_b_n", 64'(b_log.size()), 64'd5);
    bad = 0;
    for (int i = 0; i < 5 && i < a_log.size() && i < b_log.size(); i++) begin
      if (a_log[i] !== $realtobits(real'(i + 1))) bad++;
      if (b_log[i] !== $realtobits(2.0)) bad++;
    end
    chk("t1_data", 64'(bad), 64'd0);
    chk("t1_rows_done", 64'(rows_done), 64'd2);
    chk("t1_busy", 64'(busy), 64'd0);

    // 2: zero-length middle row.
    do_reset();
    push_ptr(0, 0); push_ptr(2, 0); push_ptr(2, 0); push_ptr(4, 1);
    for (int i = 0; i < 4; i++) begin val_q.push_back(64'(10 + i)); vec_q.push_back(64'(20 + i)); end
    wait_idle("t2_idle", 100);
    chk("t2_times_n", 64'(times_log.size()), 64'd3);
    chk("t2_times", {times_log[0], times_log[1]}, {32'd2, 32'd0});
    chk("t2_times2", 64'(times_log[2]), 64'd2);
    chk("t2_zero_row_gap", {32'(times_apos[1]), 32'(times_apos[2])}, {32'd2, 32'd2});
    chk("t2_b_before_next", {32'(times_bpos[1]), 32'(times_bpos[2])}, {32'd2, 32'd2});
    chk("t2_a_n", 64'(a_log.size()), 64'd4);
    chk("t2_rows_done", 64'(rows_done), 64'd3);

    // 3: A random, B held low for 10 cycles.
    do_reset();
    a_rand = 1'b1; b_low = 1'b1;
    push_ptr(0, 0); push_ptr(8, 1);
    for (int i = 0; i < 8; i++) begin val_q.push_back(64'(100 + i)); vec_q.push_back(64'(200 + i)); end
    for (int i = 0; i < 10; i++) tick();
    chk("t3_one_load", 64'(val_acc), 64'd1);
    chk("t3_a_stall", 64'(a_log.size() <= 1), 64'd1);
    chk("t3_b_none", 64'(b_log.size()), 64'd0);
    b_low = 1'b0;
    wait_idle("t3_idle", 300);
    a_rand = 1'b0;
    chk("t3_times", 64'(times_log.size() == 1 && times_log[0] == 8), 64'd1);
    chk("t3_counts", {32'(a_log.size()), 32'(b_log.size())}, {32'd8, 32'd8});
    bad = 0;
    for (int i = 0; i < a_log.size(); i++) if (a_log[i] !== 64'(100 + i)) bad++;
    for (int i = 0; i < b_log.size(); i++) if (b_log[i] !== 64'(200 + i)) bad++;
    chk("t3_order", 64'(bad), 64'd0);

    // 4: decreasing pointer.
    do_reset();
    push_ptr(10, 0); push_ptr(4, 1);
    wait_idle("t4_idle", 50);
    chk("t4_times", 64'(times_log.size() == 1 && times_log[0] == 0), 64'd1);
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_no_pairs", 64'(a_log.size() + b_log.size()), 64'd0);
    chk("t4_rows_done", 64'(rows_done), 64'd1);
    push_ptr(0, 0); push_ptr(1, 1);
    val_q.push_back(64'd7); vec_q.push_back(64'd8);
    wait_idle("t4_idle2", 50);
    chk("t4_err_sticky", 64'(err), 64'd1);
    do_reset();
    chk("t4_err_cleared", 64'(err), 64'd0);

    // 5: reset after 2 of 6 pairs.
    push_ptr(0, 0); push_ptr(6, 1);
    for (int i = 0; i < 6; i++) begin val_q.push_back(64'(30 + i)); vec_q.push_back(64'(40 + i)); end
    for (int n = 0; n < 50 && a_log.size() < 2; n++) tick();
    chk("t5_two_pairs", 64'(a_log.size()), 64'd2);
    rst = 1'b1;
    ptr_q.delete(); val_q.delete(); vec_q.delete();
    tick();
    chk("t5_valids", {61'd0, M_AXIS_TIMES_tvalid, M_AXIS_A_tvalid, M_AXIS_B_tvalid}, 64'd0);
    chk("t5_state", {31'd0, rows_done, busy, err}, 64'd0);
    rst = 1'b0;
    clear_logs();
    tick();
    push_ptr(0, 0); push_ptr(1, 1);
    val_q.push_back(64'd55); vec_q.push_back(64'd66);
    wait_idle("t5_idle", 50);
    chk("t5_times", 64'(times_log.size() == 1 && times_log[0] == 1), 64'd1);
    chk("t5_pair", {a_log.size() == 1 ? a_log[0] : 64'hdead}, 64'd55);
    chk("t5_rows_done", 64'(rows_done), 64'd1);

    // 6: 100-element row at full rate.
    do_reset();
    push_ptr(0, 0); push_ptr(100, 1);
    for (int i = 0; i < 100; i++) begin val_q.push_back(64'(i)); vec_q.push_back(64'(1000 + i)); end
    wait_idle("t6_idle", 400);
    chk("t6_counts", {32'(a_log.size()), 32'(b_log.size())}, {32'd100, 32'd100});
    if (a_log.size() == 100 && b_log.size() == 100) begin
      chk("t6_a_span", 64'(a_cyc[99] - a_cyc[0]), 64'd99);
      chk("t6_b_span", 64'(b_cyc[99] - b_cyc[0]), 64'd99);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
        if (a_log[i] !== 64'(i)) bad++;
        if (b_log[i] !== 64'(1000 + i)) bad++;
      end
      chk("t6_order", 64'(bad), 64'd0);
    end
    chk("t6_rows_done", 64'(rows_done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spmv_row_feeder.md
# spmv_row_feeder

Producer side of the per-row dot-product datapath. Consumes a CSR row-pointer stream, a matrix-value stream and a gathered-vector-element stream, and emits the three streams the dot-product kernel consumes: per-row element count (TIMES) followed by exactly that many (A, B) operand pairs. It sits between the CSR fetch/gather logic and the dot-product unit in the SpMV calc kernel, and guarantees that the number of pairs sent always matches the announced count.

## Interface

**Parameters**
- `PTR_W`, default 32: row-pointer width; also the TIMES width.
- `DATA_W`, default 64: operand width (IEEE double).

**Ports**
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `S_AXIS_ROWPTR_tdata`, in, PTR_W: CSR row pointer.
- `S_AXIS_ROWPTR_tvalid` in / `S_AXIS_ROWPTR_tready` out, 1 each.
- `S_AXIS_ROWPTR_tlast`, in, 1: marks the final pointer of a matrix.
- `S_AXIS_VAL_tdata`, in, DATA_W, with `tvalid` in / `tready` out: matrix values.
- `S_AXIS_VEC_tdata`, in, DATA_W, with `tvalid` in / `tready` out: gathered x[col] values.
- `M_AXIS_TIMES_tdata`, out, PTR_W, with `tvalid` out / `tready` in: row length.
- `M_AXIS_A_tdata`, out, DATA_W, with `tvalid` out / `tready` in: value operand.
- `M_AXIS_B_tdata`, out, DATA_W, with `tvalid` out / `tready` in: vector operand.
- `rows_done`, out, 32: rows whose last pair, or zero-length TIMES, has been accepted.
- `busy`, out, 1: high in any state other than BASE.
- `err`, out, 1: sticky; set on a decreasing row pointer.

## Operation

**State machine: BASE, PTR, TIMES, PAIRS**
- **BASE:** ROWPTR_tready=1. On accept, store the pointer as `prev` and go to PTR. A tlast accepted here (single-pointer matrix) stays in BASE with no output.
- **PTR:** ROWPTR_tready=1. On accept:
  - `len = cur - prev` (unsigned, PTR_W bits).
  - If `cur < prev`: `len = 0` and set `err`.
  - Set `prev = cur`, latch the tlast flag, go to TIMES.
- **TIMES:** TIMES_tvalid=1 with `len`, held stable until TIMES_tready.
  - On handshake with `len == 0`: increment rows_done, then go to BASE if the latched tlast is set, else PTR.
  - On handshake with `len != 0`: load `remain = len` and go to PAIRS.
- **PAIRS:** move pairs through the pair register (below) until `remain` reaches 0.
  - `remain` decrements when a pair is loaded.
  - When the last pair has been sent on both A and B: increment rows_done, then go to BASE/PTR using the latched tlast.

**Pair register**
- One entry: `a_q`, `b_q`, plus flags `a_pend` and `b_pend`.
- Load condition: state PAIRS, `remain != 0`, VAL_tvalid and VEC_tvalid both high, and the entry is free. "Free" means both pend flags are clear, or each set flag is clearing this cycle.
- VAL_tready = VEC_tready = load condition with the input valids removed from the term. Both inputs are therefore consumed only in the same cycle.
- A_tvalid = `a_pend` and B_tvalid = `b_pend`; each pend flag clears on its own handshake. A and B drain independently, since the downstream multiplier accepts them separately.
- Output valids never depend on output readies. Input readies may depend on output readies.

**Other rules**
- ROWPTR_tready is 0 in TIMES and PAIRS.
- VAL_tready and VEC_tready are 0 outside PAIRS.
- rows_done wraps modulo 2^32.

## Timing

**Reset values**
- All valids and readies: 0.
- rows_done = 0, err = 0, busy = 0, state = BASE.
- A/B/TIMES data: 0.
- In the cycle after rst deasserts, ROWPTR_tready = 1.

**Reset mid-operation**
- Abandons the row: no further pairs are emitted.
- A held TIMES_tvalid or A/B_tvalid drops to 0 in the cycle after rst is sampled.

**Latency**
- Pointer accept in PTR to TIMES_tvalid: 1 cycle.
- TIMES handshake to first VAL/VEC tready: 1 cycle.
- Pair accept to A/B_tvalid: 1 cycle.
- Sustained throughput is 1 pair per cycle when both outputs are ready every cycle.

**Boundary and overlap rules**
- TIMES for row n+1 is never issued before both the last A and the last B of row n have handshaken.
- A load may occur in the same cycle that both pend flags clear.
- A load does not occur while one flag clears and the other stays set.

## Structure

**Shared package `spmv_pkg`**
- State enum: BASE, PTR, TIMES, PAIRS.
- Default values of PTR_W and DATA_W.

**Sub-module `pair_join_reg`**
- The one-entry, two-output join register with independent A/B drain.
- Ports: load, pending flags, pair data.
- Reusable elsewhere in the kernel.

## Test plan

1. **Basic matrix.** Row ptrs 0, 3, 5 (tlast on 5); VAL 1.0..5.0; VEC all 2.0. Expect TIMES 3, then 2. A carries 1.0..5.0 in order, B carries 2.0 ×5. rows_done = 2; ends in BASE with busy = 0.
2. **Zero-length row.** Ptrs 0, 2, 2, 4. Expect TIMES 2, 0, 2. The 0 row has no A/B beats between it and the next TIMES. rows_done = 3.
3. **Independent backpressure.** A_tready is random at 50%, B_tready is held low for 10 cycles. Expect A to stall after one beat, no further VAL/VEC accept, and no data loss or duplication. All 8 pairs arrive in order.
4. **Bad pointer.** Ptrs 10, 4. Expect TIMES 0, `err` = 1 and sticky until rst, and no pairs.
5. **Reset mid-row.** Assert rst after 2 of 6 pairs. Expect all valids 0 next cycle, rows_done = 0, BASE. A new matrix 0, 1 then produces TIMES 1 and one pair.
6. **Throughput.** All readies held at 1 and a 100-element row. Expect 100 A and 100 B beats in 100 consecutive cycles.
